// File: rtl/blc_median_stream_if.sv
// Valid/ready pixel stream used on both sides of blc_median_stream.
interface blc_median_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/blc_median_stream.sv
// Streaming black-level corrector: histogram-median of the optical-black pixels sets the line reference.
// Optional temporal smoothing of the reference is enabled by defining BLC_IIR_EN.
module blc_median_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BPS_L      = 1,
    parameter int BPN_L      = 128,
    parameter int ACTIVE_N   = 16,
    parameter int BPN_R      = 128,
    parameter int TAIL_N     = 1,
    parameter int PEDESTAL   = 0,
    parameter int IIR_SHIFT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    blc_median_stream_if.slave     s_if,
    blc_median_stream_if.master    m_if,
    output logic [DATA_WIDTH-1:0]  ref_data,
    output logic                   ref_valid,
    output logic                   busy
);
    localparam int NBINS = 1 << DATA_WIDTH;
    localparam int NB    = BPN_L + BPN_R;
    localparam int CW    = $clog2(NB + 1);
    localparam int L     = BPS_L + BPN_L + ACTIVE_N + BPN_R + TAIL_N;
    localparam int PW    = $clog2(L);
    localparam int RW    = $clog2(ACTIVE_N + 1);
    localparam int BW    = (ACTIVE_N > 1) ? $clog2(ACTIVE_N) : 1;

    localparam logic [PW-1:0] P_BLK_L = PW'(BPS_L);
    localparam logic [PW-1:0] P_ACT   = PW'(BPS_L + BPN_L);
    localparam logic [PW-1:0] P_BLK_R = PW'(BPS_L + BPN_L + ACTIVE_N);
    localparam logic [PW-1:0] P_TAIL  = PW'(BPS_L + BPN_L + ACTIVE_N + BPN_R);
    localparam logic [PW-1:0] P_LAST  = PW'(L - 1);
    localparam logic [CW-1:0] RANK    = CW'((NB + 1) >> 1);
    localparam logic [RW-1:0] N_ACT   = RW'(ACTIVE_N);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_SEARCH  = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [CW-1:0]         cum_q, cum_d;
    logic                  found_q, found_d;
    logic [DATA_WIDTH-1:0] median_q, median_d;
    logic [RW-1:0]         rd_q, rd_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [DATA_WIDTH-1:0] ref_q, ref_d;
    logic                  ref_valid_q, ref_valid_d;
    logic [CW-1:0]         hist_q [NBINS];
    logic [CW-1:0]         hist_d [NBINS];
    logic [DATA_WIDTH-1:0] lbuf_q [ACTIVE_N];
    logic [DATA_WIDTH-1:0] lbuf_d [ACTIVE_N];

    logic                  accept, in_black, in_active, hit, search_done, xfer, load;
    logic [CW-1:0]         cum_sum;
    logic [DATA_WIDTH-1:0] median_next, ref_next, pix, corr;
    logic signed [DATA_WIDTH+1:0] diff;

    always_comb begin
        accept      = (state_q == ST_COLLECT) && s_if.valid;
        in_black    = ((pos_q >= P_BLK_L) && (pos_q < P_ACT)) ||
                      ((pos_q >= P_BLK_R) && (pos_q < P_TAIL));
        in_active   = (pos_q >= P_ACT) && (pos_q < P_BLK_R);
        cum_sum     = cum_q + hist_q[bin_q];
        hit         = !found_q && (cum_sum >= RANK);
        median_next = hit ? bin_q : median_q;
        search_done = (state_q == ST_SEARCH) && (bin_q == '1);
        // Headroom of two bits keeps both underflow and pedestal overflow visible before clamping.
        pix         = lbuf_q[BW'(rd_q)];
        diff        = $signed({2'b00, pix}) - $signed({2'b00, ref_q})
                      + $signed((DATA_WIDTH+2)'(PEDESTAL));
        corr        = diff[DATA_WIDTH+1] ? '0 : (diff[DATA_WIDTH] ? '1 : diff[DATA_WIDTH-1:0]);
        xfer        = m_valid_q && m_if.ready;
        load        = (state_q == ST_DRAIN) && (!m_valid_q || m_if.ready) && (rd_q != N_ACT);
    end

`ifdef BLC_IIR_EN
    localparam int ACC_W = DATA_WIDTH + IIR_SHIFT;

    logic [ACC_W-1:0]    acc_q, acc_d, med_sh, acc_upd;
    logic signed [ACC_W:0] delta, step;
    logic                primed_q, primed_d;

    // First line after reset seeds the accumulator; later lines move a 2^-IIR_SHIFT fraction toward the new median.
    always_comb begin
        med_sh   = ACC_W'(median_next) << IIR_SHIFT;
        delta    = $signed({1'b0, med_sh}) - $signed({1'b0, acc_q});
        step     = delta >>> IIR_SHIFT;
        acc_upd  = acc_q + step[ACC_W-1:0];
        acc_d    = acc_q;
        primed_d = primed_q;
        if (search_done) begin
            acc_d    = primed_q ? acc_upd : med_sh;
            primed_d = 1'b1;
        end
        ref_next = acc_d[ACC_W-1:IIR_SHIFT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            primed_q <= primed_d;
        end
    end
`else
    assign ref_next = median_next;
`endif

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        bin_d       = bin_q;
        cum_d       = cum_q;
        found_d     = found_q;
        median_d    = median_q;
        rd_d        = rd_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        ref_d       = ref_q;
        ref_valid_d = 1'b0;
        hist_d      = hist_q;
        lbuf_d      = lbuf_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (in_black)
                        hist_d[s_if.data] = hist_q[s_if.data] + CW'(1);
                    if (in_active)
                        lbuf_d[BW'(pos_q - P_ACT)] = s_if.data;
                    if (pos_q == P_LAST) begin
                        pos_d   = '0;
                        state_d = ST_SEARCH;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end
            end
            ST_SEARCH: begin
                // Reading a bin also clears it, so the histogram is empty again once the scan ends.
                hist_d[bin_q] = '0;
                cum_d         = cum_sum;
                found_d       = found_q | hit;
                median_d      = median_next;
                bin_d         = bin_q + DATA_WIDTH'(1);
                if (search_done) begin
                    state_d     = ST_DRAIN;
                    cum_d       = '0;
                    found_d     = 1'b0;
                    ref_d       = ref_next;
                    ref_valid_d = 1'b1;
                    rd_d        = '0;
                end
            end
            ST_DRAIN: begin
                if (xfer)
                    m_valid_d = 1'b0;
                if (load) begin
                    m_valid_d = 1'b1;
                    m_data_d  = corr;
                    rd_d      = rd_q + RW'(1);
                end
                if (xfer && (rd_q == N_ACT))
                    state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            pos_q       <= '0;
            bin_q       <= '0;
            cum_q       <= '0;
            found_q     <= 1'b0;
            median_q    <= '0;
            rd_q        <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            for (int i = 0; i < NBINS; i++)
                hist_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            bin_q       <= bin_d;
            cum_q       <= cum_d;
            found_q     <= found_d;
            median_q    <= median_d;
            rd_q        <= rd_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            hist_q      <= hist_d;
        end
    end

    always_ff @(posedge clk) begin
        lbuf_q <= lbuf_d;
    end

    assign s_if.ready = (state_q == ST_COLLECT);
    assign m_if.valid = m_valid_q;
    assign m_if.data  = m_data_q;
    assign ref_data   = ref_q;
    assign ref_valid  = ref_valid_q;
    assign busy       = (state_q != ST_COLLECT);
endmodule

// File: tb/tb_blc_median_stream.sv
// Directed bench for blc_median_stream: two instances (PEDESTAL 0 and 16) fed the same lines.
// Expected references follow the BLC_IIR_EN setting of the build.
module tb_blc_median_stream;
    localparam int W         = 8;
    localparam int BPS_L     = 1;
    localparam int BPN_L     = 128;
    localparam int ACTIVE_N  = 16;
    localparam int BPN_R     = 128;
    localparam int TAIL_N    = 1;
    localparam int IIR_SHIFT = 2;
    localparam int L         = BPS_L + BPN_L + ACTIVE_N + BPN_R + TAIL_N;
    localparam int ACT_LO    = BPS_L + BPN_L;
    localparam int ACT_HI    = ACT_LO + ACTIVE_N;
    localparam int R_HI      = ACT_HI + BPN_R;

    logic         clk;
    logic         rst;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         m_ready;
    logic [W-1:0] ref_a, ref_b;
    logic         ref_valid_a, ref_valid_b, busy_a, busy_b;

    int n_cmp;
    int n_fail;
    int blk [BPN_L + BPN_R];
    int act [ACTIVE_N];
    int sat_tab [ACTIVE_N] = '{5, 255, 0, 10, 11, 9, 128, 200, 15, 16, 17, 100, 254, 1, 3, 250};
    int ref_m;
    int acc_m;
    bit primed_m;
    logic [15:0] bp_pat = 16'b1011_0010_1110_0101;

    blc_median_stream_if #(.DATA_WIDTH(W)) sa_if ();
    blc_median_stream_if #(.DATA_WIDTH(W)) ma_if ();
    blc_median_stream_if #(.DATA_WIDTH(W)) sb_if ();
    blc_median_stream_if #(.DATA_WIDTH(W)) mb_if ();

    assign sa_if.valid = s_valid;
    assign sa_if.data  = s_data;
    assign sb_if.valid = s_valid;
    assign sb_if.data  = s_data;
    assign ma_if.ready = m_ready;
    assign mb_if.ready = m_ready;

    blc_median_stream #(.DATA_WIDTH(W), .BPS_L(BPS_L), .BPN_L(BPN_L), .ACTIVE_N(ACTIVE_N),
                        .BPN_R(BPN_R), .TAIL_N(TAIL_N), .PEDESTAL(0), .IIR_SHIFT(IIR_SHIFT))
    dut_a (.clk(clk), .rst(rst), .s_if(sa_if), .m_if(ma_if),
           .ref_data(ref_a), .ref_valid(ref_valid_a), .busy(busy_a));

    blc_median_stream #(.DATA_WIDTH(W), .BPS_L(BPS_L), .BPN_L(BPN_L), .ACTIVE_N(ACTIVE_N),
                        .BPN_R(BPN_R), .TAIL_N(TAIL_N), .PEDESTAL(16), .IIR_SHIFT(IIR_SHIFT))
    dut_b (.clk(clk), .rst(rst), .s_if(sb_if), .m_if(mb_if),
           .ref_data(ref_b), .ref_valid(ref_valid_b), .busy(busy_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Skip pixels carry 77 so that miscounting them as black shifts the median.
    function automatic int pixAt(input int p);
        if (p < BPS_L)  return 77;
        if (p < ACT_LO) return blk[p - BPS_L];
        if (p < ACT_HI) return act[p - ACT_LO];
        if (p < R_HI)   return blk[BPN_L + p - ACT_HI];
        return 77;
    endfunction

    task automatic modelRef(input int med);
`ifdef BLC_IIR_EN
        if (!primed_m) acc_m = med << IIR_SHIFT;
        else           acc_m = acc_m + (((med << IIR_SHIFT) - acc_m) >>> IIR_SHIFT);
        primed_m = 1'b1;
        ref_m    = acc_m >> IIR_SHIFT;
`else
        ref_m = med;
`endif
    endtask

    task automatic doReset;
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick;
        tick;
        rst      = 1'b0;
        primed_m = 1'b0;
        acc_m    = 0;
    endtask

    task automatic applyStimulus(input int n_pix, input bit gaps);
        for (int i = 0; i < n_pix; i++) begin
            if (gaps && (i % 5 == 2)) begin
                s_valid = 1'b0;
                s_data  = 8'hEE;
                tick;
            end
            s_valid = 1'b1;
            s_data  = W'(pixAt(i));
            tick;
        end
        s_valid = 1'b0;
        if (n_pix == L) begin
            checkOutput("busy_search", busy_a, 1);
            checkOutput("s_ready_search", sa_if.ready, 0);
        end
    endtask

    task automatic drainLine(input bit bp, input int stop_after);
        int  n, k, budget;
        bit  mr, prev_stall;
        n = 0;
        while (ref_valid_a !== 1'b1 && n < 600) begin
            tick;
            n++;
        end
        checkOutput("ref_valid_latency", n, 256);
        checkOutput("ref_data_a", ref_a, ref_m);
        checkOutput("ref_data_b", ref_b, ref_m);
        m_ready = 1'b1;
        tick;
        checkOutput("ref_valid_pulse", ref_valid_a, 0);
        checkOutput("m_valid_rise", ma_if.valid, 1);
        k = 0;
        budget = 200;
        prev_stall = 1'b0;
        while (k < ACTIVE_N && k != stop_after && budget > 0) begin
            mr = bp ? bp_pat[(k + budget) % 16] : 1'b1;
            m_ready = mr;
            if (prev_stall) checkOutput("m_valid_held", ma_if.valid, 1);
            if (ma_if.valid) begin
                checkOutput("m_data_a", ma_if.data, clamp8(act[k] - ref_m));
                checkOutput("m_data_b", mb_if.data, clamp8(act[k] - ref_m + 16));
                if (mr) k++;
            end
            prev_stall = ma_if.valid && !mr;
            tick;
            budget--;
        end
        if (stop_after < 0) begin
            checkOutput("drain_count", k, ACTIVE_N);
            checkOutput("s_ready_after_drain", sa_if.ready, 1);
            checkOutput("m_valid_after_drain", ma_if.valid, 0);
            checkOutput("busy_after_drain", busy_a, 0);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        ref_m    = 0;
        acc_m    = 0;
        primed_m = 1'b0;

        doReset;
        checkOutput("rst_s_ready", sa_if.ready, 1);
        checkOutput("rst_m_valid", ma_if.valid, 0);
        checkOutput("rst_m_data", ma_if.data, 0);
        checkOutput("rst_ref_data", ref_a, 0);
        checkOutput("rst_ref_valid", ref_valid_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_m_valid_b", mb_if.valid, 0);
        checkOutput("rst_m_data_b", mb_if.data, 0);
        checkOutput("rst_ref_valid_b", ref_valid_b, 0);
        checkOutput("rst_busy_b", busy_b, 0);

        // Basic correction: black all 10, active 30..45.
        foreach (blk[i]) blk[i] = 10;
        foreach (act[i]) act[i] = 30 + i;
        applyStimulus(L, 1'b0);
        modelRef(10);
        drainLine(1'b0, -1);

        // Median selection: each value 0..255 once gives lower median 127.
        foreach (blk[i]) blk[i] = i;
        foreach (act[i]) act[i] = i * 17;
        applyStimulus(L, 1'b0);
        modelRef(127);
        drainLine(1'b0, -1);

        // Saturation both ways, with gapped input and stalled output.
        foreach (blk[i]) blk[i] = 10;
        act = sat_tab;
        applyStimulus(L, 1'b1);
        modelRef(10);
        drainLine(1'b1, -1);

        // Reset after five outputs.
        foreach (blk[i]) blk[i] = 200;
        foreach (act[i]) act[i] = 100 + i * 5;
        applyStimulus(L, 1'b0);
        modelRef(200);
        drainLine(1'b0, 5);
        rst = 1'b1;
        tick;
        checkOutput("m_valid_mid_rst", ma_if.valid, 0);
        checkOutput("s_ready_mid_rst", sa_if.ready, 1);
        checkOutput("busy_mid_rst", busy_a, 0);
        rst      = 1'b0;
        primed_m = 1'b0;
        acc_m    = 0;

        // Partial line of zeros aborted by reset; its counts must not survive.
        foreach (blk[i]) blk[i] = 0;
        applyStimulus(140, 1'b0);
        doReset;
        foreach (blk[i]) blk[i] = 50;
        foreach (act[i]) act[i] = 50 + i;
        applyStimulus(L, 1'b0);
        modelRef(50);
        drainLine(1'b0, -1);

        // Two lines with medians 100 then 20 straight after reset.
        doReset;
        foreach (blk[i]) blk[i] = (i < 100) ? 5 : ((i < 200) ? 100 : 240);
        foreach (act[i]) act[i] = i * 16;
        applyStimulus(L, 1'b0);
        modelRef(100);
        drainLine(1'b0, -1);
        foreach (blk[i]) blk[i] = (i < 128) ? 20 : 250;
        foreach (act[i]) act[i] = 255 - i * 3;
        applyStimulus(L, 1'b0);
        modelRef(20);
        drainLine(1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
